// File: rtl/cpu_test_pkg.sv
// Shared types and constants for the RV32I self-test harness and its benches.
package cpu_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_t;

    // jal x0, 0 : the core spins on itself once the program is finished
    localparam logic [31:0] HALT_INSN_DEF = 32'h0000006f;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

endpackage

// File: rtl/cpu_selftest_harness_halt_detector.sv
// Detects a core parked on the halt instruction: same PC and halt word for HALT_CYCLES cycles.
module halt_detector
    import cpu_test_pkg::*;
#(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   HALT_INSN   = XLEN'(HALT_INSN_DEF),
    parameter int                HALT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] cpu_pc,
    input  logic [XLEN-1:0] cpu_instr,
    output logic            halt
);

    localparam int SW = $clog2(HALT_CYCLES + 1);

    logic [XLEN-1:0] pc_q;
    logic [SW-1:0]   stable;

    always_ff @(posedge clk) begin
        pc_q <= cpu_pc;
    end

    // A multicycle core holds PC between instructions, so the instruction word must match too
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            stable <= '0;
        end else if (cpu_instr == HALT_INSN && cpu_pc == pc_q) begin
            if (stable != SW'(HALT_CYCLES))
                stable <= stable + 1'b1;
        end else begin
            stable <= '0;
        end
    end

    assign halt = en && (stable == SW'(HALT_CYCLES));

endmodule

// File: rtl/cpu_selftest_harness.sv
// Run-and-check harness: streams a program into imem, runs the core to halt or timeout, then checks registers.
module cpu_selftest_harness
    import cpu_test_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              PROG_DEPTH  = 64,
    parameter logic [XLEN-1:0] HALT_INSN   = XLEN'(HALT_INSN_DEF),
    parameter int              HALT_CYCLES = 16,
    parameter int              TIMEOUT     = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          ld_valid,
    input  logic [XLEN-1:0]               ld_data,
    input  logic                          ld_last,
    output logic                          ld_ready,
    output logic                          imem_we,
    output logic [$clog2(PROG_DEPTH)-1:0] imem_addr,
    output logic [XLEN-1:0]               imem_wdata,
    output logic                          cpu_rst,
    input  logic [XLEN-1:0]               cpu_pc,
    input  logic [XLEN-1:0]               cpu_instr,
    input  logic                          chk_valid,
    input  logic [4:0]                    chk_reg,
    input  logic [XLEN-1:0]               chk_exp,
    input  logic                          chk_last,
    output logic                          chk_ready,
    output logic [4:0]                    rf_raddr,
    input  logic [XLEN-1:0]               rf_rdata,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic                          load_err,
    output logic [7:0]                    fail_count,
    output logic [4:0]                    first_fail_reg
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t        state;
    logic [AW-1:0] wcnt;
    logic [CW-1:0] cyc;
    logic          run_en;
    logic          halt;
    logic          ld_fire;
    logic          chk_fire;
    logic          mismatch;

    assign ld_ready   = (state == ST_LOAD);
    assign chk_ready  = (state == ST_CHECK);
    assign run_en     = (state == ST_RUN);
    assign ld_fire    = ld_valid && ld_ready;
    assign chk_fire   = chk_valid && chk_ready;
    assign mismatch   = chk_fire && (rf_rdata != chk_exp);

    // Memory and register-file side effects are combinational so a word moves every accepted cycle
    assign imem_we    = ld_fire;
    assign imem_addr  = ld_ready ? wcnt : '0;
    assign imem_wdata = ld_fire ? ld_data : '0;
    assign rf_raddr   = chk_ready ? chk_reg : '0;

    halt_detector #(
        .XLEN        (XLEN),
        .HALT_INSN   (HALT_INSN),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt (
        .clk       (clk),
        .rst       (rst),
        .en        (run_en),
        .cpu_pc    (cpu_pc),
        .cpu_instr (cpu_instr),
        .halt      (halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cpu_rst        <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            load_err       <= 1'b0;
            fail_count     <= 8'd0;
            first_fail_reg <= 5'd0;
            wcnt           <= '0;
            cyc            <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_LOAD;
                        cpu_rst        <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        load_err       <= 1'b0;
                        fail_count     <= 8'd0;
                        first_fail_reg <= 5'd0;
                        wcnt           <= '0;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        wcnt <= wcnt + 1'b1;
                        if (ld_last) begin
                            state   <= ST_RUN;
                            cpu_rst <= 1'b0;
                            cyc     <= '0;
                        end else if (wcnt == AW'(PROG_DEPTH - 1)) begin
                            state    <= ST_DONE;
                            load_err <= 1'b1;
                            done     <= 1'b1;
                            pass     <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    // Halt is tested first so a halt on the final allowed cycle still gets checked
                    if (halt) begin
                        state <= ST_CHECK;
                    end else if (cyc == CW'(TIMEOUT - 1)) begin
                        state   <= ST_DONE;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (chk_fire) begin
                        if (mismatch) begin
                            fail_count <= sat_inc(fail_count);
                            if (fail_count == 8'd0)
                                first_fail_reg <= chk_reg;
                        end
                        if (chk_last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= (fail_count == 8'd0) && !mismatch && !timeout && !load_err;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_selftest_harness.sv
// Bench: a behavioural RV32I subset core drives the harness; session outcomes come from a reference model.
module tb_cpu_selftest_harness;
    import cpu_test_pkg::*;

    localparam int PD = 16;
    localparam int AW = $clog2(PD);
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic [31:0]   cpu_pc;
    logic [31:0]   cpu_instr;
    logic          chk_valid = 1'b0;
    logic [4:0]    chk_reg = '0;
    logic [31:0]   chk_exp = '0;
    logic          chk_last = 1'b0;
    logic          chk_ready;
    logic [4:0]    rf_raddr;
    logic [31:0]   rf_rdata;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          load_err;
    logic [7:0]    fail_count;
    logic [4:0]    first_fail_reg;

    cpu_selftest_harness #(
        .XLEN(32), .PROG_DEPTH(PD), .HALT_INSN(32'h0000006f), .HALT_CYCLES(16), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .chk_valid(chk_valid), .chk_reg(chk_reg), .chk_exp(chk_exp), .chk_last(chk_last),
        .chk_ready(chk_ready), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .done(done), .pass(pass), .timeout(timeout), .load_err(load_err),
        .fail_count(fail_count), .first_fail_reg(first_fail_reg)
    );

    always #5 clk = ~clk;

    // Behavioural multicycle core: holds PC/instr for 1-4 cycles per instruction
    logic [31:0] imem_m [0:PD-1];
    logic [31:0] regs [0:31];
    logic [31:0] pc;
    logic [31:0] cur;
    int          busy;

    always @(posedge clk) if (imem_we) imem_m[imem_addr] <= imem_wdata;

    assign cur       = imem_m[pc[AW+1:2]];
    assign cpu_pc    = pc;
    assign cpu_instr = cur;
    assign rf_rdata  = regs[rf_raddr];

    function automatic logic [31:0] iimm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic writes_rd(input logic [31:0] ins);
        return ins[6:0] == 7'b0010011 || ins[6:0] == 7'b0110011 ||
               ins[6:0] == OPC_JAL || ins[6:0] == OPC_JALR;
    endfunction

    function automatic logic [31:0] exec_result(input logic [31:0] ins, pcv, a, b);
        case (ins[6:0])
            OPC_JAL, OPC_JALR: return pcv + 32'd4;
            7'b0010011:        return a + iimm(ins);
            7'b0110011:        return a + b;
            default:           return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exec_next_pc(input logic [31:0] ins, pcv, a);
        case (ins[6:0])
            OPC_JAL:  return pcv + jimm(ins);
            OPC_JALR: return (a + iimm(ins)) & ~32'd1;
            default:  return pcv + 32'd4;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cpu_rst) begin
            pc   <= 32'd0;
            busy <= 0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (busy != 0) begin
            busy <= busy - 1;
        end else begin
            if (writes_rd(cur) && cur[11:7] != 5'd0)
                regs[cur[11:7]] <= exec_result(cur, pc, regs[cur[19:15]], regs[cur[24:20]]);
            pc   <= exec_next_pc(cur, pc, regs[cur[19:15]]);
            busy <= int'($urandom_range(0, 3));
        end
    end

    // Architectural results of the jump program, derived by hand
    logic [31:0] ref_regs [0:31];
    logic [31:0] jump_prog [0:10] = '{
        32'h01000113, 32'h0aa00193, 32'h00010067, 32'h00000193, 32'h0bb00213,
        32'h0080006f, 32'h00000213, 32'h00100293, 32'h00418333, 32'h00000013,
        32'h0000006f};

    logic [31:0] prog_q[$];
    logic [4:0]  creg_q[$];
    logic [31:0] cexp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic use_jump_prog();
        prog_q.delete();
        foreach (jump_prog[i]) prog_q.push_back(jump_prog[i]);
    endtask

    task automatic load_prog(input int n, input bit mark_last);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            repeat ($urandom_range(0, 2)) tick();
            ld_valid = 1'b1;
            ld_data  = prog_q[i];
            ld_last  = mark_last && (i == n - 1);
            @(negedge clk);
            while (!ld_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            expect_eq("ld_ready", 32'(ld_ready), 32'd1);
            expect_eq("imem_we", 32'(imem_we), 32'd1);
            expect_eq("imem_addr", 32'(imem_addr), 32'(i));
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (w >= 50) return;
        end
    endtask

    task automatic check_imem(input int n);
        for (int i = 0; i < n; i++) expect_eq("imem_word", imem_m[i], prog_q[i]);
    endtask

    task automatic run_checks();
        for (int i = 0; i < creg_q.size(); i++) begin
            int w = 0;
            repeat ($urandom_range(0, 2)) tick();
            chk_valid = 1'b1;
            chk_reg   = creg_q[i];
            chk_exp   = cexp_q[i];
            chk_last  = (i == creg_q.size() - 1);
            @(negedge clk);
            while (!chk_ready && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 1000) begin
                expect_eq("chk_ready_wait", 32'(chk_ready), 32'd1);
                chk_valid = 1'b0;
                chk_last  = 1'b0;
                return;
            end
            if (i < 4) expect_eq("rf_raddr", 32'(rf_raddr), 32'(creg_q[i]));
            tick();
            chk_valid = 1'b0;
            chk_last  = 1'b0;
        end
    endtask

    task automatic expect_outcome(input string tag);
        int fc = 0;
        int ffr = 0;
        for (int i = 0; i < creg_q.size(); i++) begin
            if (cexp_q[i] != ref_regs[creg_q[i]]) begin
                if (fc == 0) ffr = creg_q[i];
                if (fc < 255) fc++;
            end
        end
        expect_eq({tag, "_done"}, 32'(done), 32'd1);
        expect_eq({tag, "_pass"}, 32'(pass), 32'(fc == 0));
        expect_eq({tag, "_fail_count"}, 32'(fail_count), 32'(fc));
        expect_eq({tag, "_first_fail"}, 32'(first_fail_reg), 32'(ffr));
        expect_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic add_check(input int r, input logic [31:0] e);
        creg_q.push_back(5'(r));
        cexp_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw_chk;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_regs[2] = 32'd16;
        ref_regs[3] = 32'd170;
        ref_regs[4] = 32'd187;
        ref_regs[5] = 32'd1;
        ref_regs[6] = 32'd357;

        repeat (3) tick();
        rst = 1'b0;
        expect_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        expect_eq("rst_done", 32'(done), 32'd0);
        expect_eq("rst_pass", 32'(pass), 32'd0);
        expect_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
        expect_eq("rst_chk_ready", 32'(chk_ready), 32'd0);
        expect_eq("rst_fail_count", 32'(fail_count), 32'd0);
        expect_eq("rst_flags", {30'd0, timeout, load_err}, 32'd0);

        // Passing session on the jump program
        use_jump_prog();
        pulse_start();
        expect_eq("load_ld_ready", 32'(ld_ready), 32'd1);
        expect_eq("load_cpu_rst", 32'(cpu_rst), 32'd1);
        load_prog(11, 1'b1);
        expect_eq("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check_imem(11);
        creg_q.delete(); cexp_q.delete();
        add_check(3, 32'd170);
        add_check(4, 32'd187);
        run_checks();
        expect_outcome("jump_pass");

        // One deliberate mismatch on x4
        pulse_start();
        load_prog(11, 1'b1);
        creg_q.delete(); cexp_q.delete();
        add_check(3, 32'd170);
        add_check(4, 32'd0);
        run_checks();
        expect_outcome("jump_x4");

        // Random check list against the reference results
        pulse_start();
        load_prog(11, 1'b1);
        creg_q.delete(); cexp_q.delete();
        for (int i = 0; i < 20; i++) begin
            int r = int'($urandom_range(0, 7));
            add_check(r, ($urandom_range(0, 1) == 0) ? ref_regs[r] : ref_regs[r] ^ $urandom_range(1, 255));
        end
        run_checks();
        expect_outcome("jump_rand");

        // Endless loop: addi x1,x1,1 ; jal x0,-4
        prog_q.delete();
        prog_q.push_back(32'h00108093);
        prog_q.push_back(32'hffdff06f);
        pulse_start();
        load_prog(2, 1'b1);
        n = 0;
        saw_chk = 1'b0;
        while (!timeout && n < 2 * TO) begin
            tick();
            n++;
            if (chk_ready) saw_chk = 1'b1;
        end
        expect_eq("to_cycles", 32'(n), 32'(TO));
        expect_eq("to_timeout", 32'(timeout), 32'd1);
        expect_eq("to_done", 32'(done), 32'd1);
        expect_eq("to_pass", 32'(pass), 32'd0);
        expect_eq("to_no_check", 32'(saw_chk), 32'd0);

        // Program one word longer than the memory
        prog_q.delete();
        for (int i = 0; i < PD + 1; i++) prog_q.push_back($urandom);
        pulse_start();
        expect_eq("le_cleared", {29'd0, timeout, done, load_err}, 32'd0);
        load_prog(PD, 1'b0);
        check_imem(PD);
        expect_eq("le_load_err", 32'(load_err), 32'd1);
        expect_eq("le_done", 32'(done), 32'd1);
        expect_eq("le_pass", 32'(pass), 32'd0);
        ld_valid = 1'b1;
        ld_data  = prog_q[PD];
        ld_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("le_ld_ready", 32'(ld_ready), 32'd0);
            expect_eq("le_imem_we", 32'(imem_we), 32'd0);
        end
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        // Reset in the middle of a run
        use_jump_prog();
        pulse_start();
        load_prog(11, 1'b1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_eq("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        expect_eq("mid_rst_done", 32'(done), 32'd0);
        expect_eq("mid_rst_idle", {30'd0, ld_ready, chk_ready}, 32'd0);
        pulse_start();
        load_prog(11, 1'b1);
        creg_q.delete(); cexp_q.delete();
        add_check(3, 32'd170);
        add_check(4, 32'd187);
        add_check(6, 32'd357);
        run_checks();
        expect_outcome("after_rst");

        // Saturation with 300 mismatching entries
        pulse_start();
        load_prog(11, 1'b1);
        check_imem(11);
        creg_q.delete(); cexp_q.delete();
        for (int i = 0; i < 300; i++) begin
            int r = int'($urandom_range(1, 6));
            add_check(r, ref_regs[r] ^ 32'h1);
        end
        run_checks();
        expect_outcome("saturate");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
